// File: rtl/serial_parity_rx.sv
// Serial-to-parallel receiver: shifts in WIDTH data bits LSB first, then one
// parity bit, and presents the word with a parity-error flag over valid/ready.
module serial_parity_rx #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_PAR  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic             acc_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_parity_q;
    logic             out_err_q;
    logic             out_valid_q;
    logic             accept_c;

    assign accept_c   = in_valid & in_ready_q;

    assign in_ready   = in_ready_q;
    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;
    assign out_err    = out_err_q;
    assign out_valid  = out_valid_q;

    // Frame FSM; in_ready is registered and only drops while a word is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_DATA;
            cnt_q        <= '0;
            sr_q         <= '0;
            acc_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
        end else if (clr) begin
            // Abort wins over any bit presented this cycle; a held word is dropped.
            state_q    <= S_DATA;
            cnt_q      <= '0;
            sr_q       <= '0;
            acc_q      <= 1'b0;
            in_ready_q <= 1'b1;
            if (state_q == S_HOLD) begin
                out_valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                S_DATA: begin
                    if (accept_c) begin
                        sr_q  <= {in_bit, sr_q[WIDTH-1:1]};
                        acc_q <= acc_q ^ in_bit;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            state_q <= S_PAR;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_PAR: begin
                    if (accept_c) begin
                        out_data_q   <= sr_q;
                        out_parity_q <= in_bit;
                        out_err_q    <= (acc_q ^ ODD_PARITY) != in_bit;
                        out_valid_q  <= 1'b1;
                        in_ready_q   <= 1'b0;
                        sr_q         <= '0;
                        acc_q        <= 1'b0;
                        state_q      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_DATA;
                    end
                end
                default: begin
                    state_q    <= S_DATA;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: even- and odd-parity instances share stimulus and
// are compared every cycle against a bit-queue reference model.
module tb_serial_parity_rx;

    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;

    logic             in_ready_e, out_parity_e, out_err_e, out_valid_e;
    logic [WIDTH-1:0] out_data_e;
    logic             in_ready_o, out_parity_o, out_err_o, out_valid_o;
    logic [WIDTH-1:0] out_data_o;

    always #5 clk = ~clk;

    serial_parity_rx #(.WIDTH(WIDTH), .ODD_PARITY(1'b0)) dut_e (
        .clk(clk), .rst(rst), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready_e), .out_data(out_data_e), .out_parity(out_parity_e),
        .out_err(out_err_e), .out_valid(out_valid_e), .out_ready(out_ready)
    );

    serial_parity_rx #(.WIDTH(WIDTH), .ODD_PARITY(1'b1)) dut_o (
        .clk(clk), .rst(rst), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready_o), .out_data(out_data_o), .out_parity(out_parity_o),
        .out_err(out_err_o), .out_valid(out_valid_o), .out_ready(out_ready)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: bits of the current frame, plus the word on offer.
    logic       mq[$];
    logic       m_ready = 1'b1;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_par = 1'b0;
    logic       m_err_e = 1'b0;
    logic       m_err_o = 1'b0;
    logic       last_acc = 1'b0;
    logic       prev_valid = 1'b0;
    int         cyc = 0;
    int         rises[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic v, input logic b, input logic r,
                              input logic c, input logic rs);
        int w;
        int ones;
        last_acc = 1'b0;
        if (rs) begin
            mq.delete();
            m_ready = 1'b1; m_valid = 1'b0; m_data = 8'h00;
            m_par = 1'b0; m_err_e = 1'b0; m_err_o = 1'b0;
        end else if (c) begin
            mq.delete();
            m_valid = 1'b0;
            m_ready = 1'b1;
        end else if (m_valid) begin
            if (r) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end else if (v && m_ready) begin
            last_acc = 1'b1;
            if (mq.size() < WIDTH) begin
                mq.push_back(b);
            end else begin
                w = 0;
                foreach (mq[i]) w += int'(mq[i]) << i;
                ones    = $countones(w);
                m_data  = 8'(w);
                m_par   = b;
                m_err_e = (int'(b) != (ones % 2));
                m_err_o = (int'(b) != (1 - (ones % 2)));
                m_valid = 1'b1;
                m_ready = 1'b0;
                mq.delete();
            end
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, compare 1 ns later.
    task automatic step(input logic v, input logic b, input logic r,
                        input logic c, input logic rs);
        @(negedge clk);
        in_valid = v; in_bit = b; out_ready = r; clr = c; rst = rs;
        @(posedge clk);
        model_edge(v, b, r, c, rs);
        #1;
        cyc++;
        check("in_ready_e", 32'(in_ready_e), 32'(m_ready));
        check("in_ready_o", 32'(in_ready_o), 32'(m_ready));
        check("out_valid_e", 32'(out_valid_e), 32'(m_valid));
        check("out_valid_o", 32'(out_valid_o), 32'(m_valid));
        check("out_data_e", 32'(out_data_e), 32'(m_data));
        check("out_data_o", 32'(out_data_o), 32'(m_data));
        check("out_parity_e", 32'(out_parity_e), 32'(m_par));
        check("out_parity_o", 32'(out_parity_o), 32'(m_par));
        check("out_err_e", 32'(out_err_e), 32'(m_err_e));
        check("out_err_o", 32'(out_err_o), 32'(m_err_o));
        if (out_valid_e && !prev_valid) rises.push_back(cyc);
        prev_valid = out_valid_e;
    endtask

    // Present one bit until the model says it was taken.
    task automatic send_bit(input logic b, input logic r);
        int n;
        n = 0;
        do begin
            step(1'b1, b, r, 1'b0, 1'b0);
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] word, input logic par, input logic r);
        for (int i = 0; i < WIDTH; i++) send_bit(word[i], r);
        send_bit(par, r);
    endtask

    initial begin
        // Reset held two cycles with in_valid high.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_valid", 32'(out_valid_e), 32'd0);
        check("rst_data", 32'(out_data_e), 32'h00);
        check("rst_ready", 32'(in_ready_e), 32'd1);

        // Good even-parity frame; no stray bit counted after reset release.
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_valid", 32'(out_valid_e), 32'd1);
        check("a5_data", 32'(out_data_e), 32'hA5);
        check("a5_err_e", 32'(out_err_e), 32'd0);
        check("a5_ready", 32'(in_ready_e), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("a5_pulse", 32'(out_valid_e), 32'd0);
        check("a5_ready_back", 32'(in_ready_e), 32'd1);

        // Parity error detection on both polarities.
        send_frame(8'h07, 1'b0, 1'b1);
        check("07p0_err_e", 32'(out_err_e), 32'd1);
        check("07p0_err_o", 32'(out_err_o), 32'd0);
        send_frame(8'h07, 1'b1, 1'b1);
        check("07p1_err_e", 32'(out_err_e), 32'd0);
        check("07p1_err_o", 32'(out_err_o), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Input gaps and output backpressure.
        for (int i = 0; i < WIDTH; i++) begin
            if (i == 4) begin
                step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            send_bit(i >= 2 && i <= 5, 1'b0);
        end
        send_bit(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            check("bp_data", 32'(out_data_e), 32'h3C);
            check("bp_ready", 32'(in_ready_e), 32'd0);
            check("bp_valid", 32'(out_valid_e), 32'd1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Abort after 3 bits, clr with a bit offered, then a clean frame.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1);
        check("abort_data", 32'(out_data_e), 32'h3C);
        check("abort_err", 32'(out_err_e), 32'd0);

        // Back-to-back frames: pulses WIDTH+2 cycles apart.
        rises.delete();
        send_frame(8'h01, 1'b1, 1'b1);
        check("b2b_err1", 32'(out_err_e), 32'd0);
        send_frame(8'hFF, 1'b0, 1'b1);
        check("b2b_err2", 32'(out_err_e), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("b2b_pulses", 32'(rises.size()), 32'd2);
        if (rises.size() == 2) check("b2b_period", 32'(rises[1] - rises[0]), 32'd10);

        // Randomized traffic with occasional aborts and resets.
        for (int n = 0; n < 800; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom()),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
